// File: rtl/gbt_chk_pkg.sv
// Shared types and default sizing for the GBT RX counter checker.
// No logic; constants only.
// No flow control.
package gbt_chk_pkg;

    typedef enum logic [1:0] {IDLE, SEED, ACQ, LOCKED} chk_state_t;

    localparam int DATA_W_DEF       = 32;
    localparam int CNT_W_DEF        = 16;
    localparam int LOCK_COUNT_DEF   = 8;
    localparam int UNLOCK_COUNT_DEF = 4;

endpackage

// File: rtl/gbt_chk_sat_counter.sv
// Saturating up-counter; clear has priority over increment.
// Latency: one clk_ik from inc_i/clr_i to cnt_o.
// No backpressure: inc_i is sampled every cycle.
module gbt_chk_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk_ik,
    input  logic         rst_ir,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk_ik or posedge rst_ir) begin
        if (rst_ir) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/gbt_rx_counter_checker.sv
// Checks the GBT RX payload against an incrementing counter; lock FSM, error counters, optional first-mismatch capture (GBT_CHK_CAPTURE_EN).
// Latency: all outputs registered, one clk_ik after the sampling edge.
// No backpressure: words are consumed whenever clken_i and rxready_i are high.
module gbt_rx_counter_checker
    import gbt_chk_pkg::*;
#(
    parameter int DATA_W       = DATA_W_DEF,
    parameter int CNT_W        = CNT_W_DEF,
    parameter int LOCK_COUNT   = LOCK_COUNT_DEF,
    parameter int UNLOCK_COUNT = UNLOCK_COUNT_DEF
) (
    input  logic              clk_ik,
    input  logic              rst_ir,
    input  logic              rxready_i,
    input  logic              clken_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              clear_i,
    output logic              locked_o,
    output logic              error_o,
    output logic              lost_lock_o,
    output logic [CNT_W-1:0]  err_cnt_o,
    output logic [CNT_W-1:0]  frame_cnt_o,
    output logic [DATA_W-1:0] cap_rx_o,
    output logic [DATA_W-1:0] cap_exp_o
);

    localparam int RUN_MAX = (LOCK_COUNT > UNLOCK_COUNT) ? LOCK_COUNT : UNLOCK_COUNT;
    localparam int RUN_W   = $clog2(RUN_MAX + 1);

    chk_state_t        state_q, state_d;
    logic [DATA_W-1:0] exp_q, exp_d;
    logic [RUN_W-1:0]  good_q, good_d, bad_q, bad_d;
    logic              error_q, error_d, locked_q, locked_d, lost_q, lost_d;
    logic              word_vld, match, err_inc, frame_inc, lost_set;

    assign word_vld = clken_i & rxready_i;
    assign match    = (data_i == exp_q);

    always_comb begin
        state_d   = state_q;
        exp_d     = exp_q;
        good_d    = good_q;
        bad_d     = bad_q;
        error_d   = 1'b0;
        err_inc   = 1'b0;
        frame_inc = 1'b0;
        lost_set  = 1'b0;
        if (!rxready_i) begin
            state_d = IDLE;
        end else begin
            // Expected always follows the last word so a restarted TX counter resyncs.
            if (word_vld && (state_q != IDLE)) begin
                exp_d = data_i + DATA_W'(1);
            end
            case (state_q)
                IDLE: state_d = SEED;
                SEED: begin
                    if (word_vld) begin
                        good_d  = '0;
                        state_d = ACQ;
                    end
                end
                ACQ: begin
                    if (word_vld) begin
                        if (match) begin
                            good_d = good_q + RUN_W'(1);
                            if (good_d == RUN_W'(LOCK_COUNT)) begin
                                state_d = LOCKED;
                                bad_d   = '0;
                            end
                        end else begin
                            good_d  = '0;
                            error_d = 1'b1;
                        end
                    end
                end
                LOCKED: begin
                    if (word_vld) begin
                        frame_inc = 1'b1;
                        if (match) begin
                            bad_d = '0;
                        end else begin
                            error_d = 1'b1;
                            err_inc = 1'b1;
                            bad_d   = bad_q + RUN_W'(1);
                            if (bad_d == RUN_W'(UNLOCK_COUNT)) begin
                                state_d  = SEED;
                                lost_set = 1'b1;
                            end
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        locked_d = (state_d == LOCKED);
        lost_d   = lost_set | (lost_q & ~clear_i);
    end

    always_ff @(posedge clk_ik or posedge rst_ir) begin
        if (rst_ir) begin
            state_q  <= IDLE;
            exp_q    <= '0;
            good_q   <= '0;
            bad_q    <= '0;
            error_q  <= 1'b0;
            locked_q <= 1'b0;
            lost_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            exp_q    <= exp_d;
            good_q   <= good_d;
            bad_q    <= bad_d;
            error_q  <= error_d;
            locked_q <= locked_d;
            lost_q   <= lost_d;
        end
    end

    gbt_chk_sat_counter #(.W(CNT_W)) u_err_cnt (
        .clk_ik (clk_ik),
        .rst_ir (rst_ir),
        .clr_i  (clear_i),
        .inc_i  (err_inc),
        .cnt_o  (err_cnt_o)
    );

    gbt_chk_sat_counter #(.W(CNT_W)) u_frame_cnt (
        .clk_ik (clk_ik),
        .rst_ir (rst_ir),
        .clr_i  (clear_i),
        .inc_i  (frame_inc),
        .cnt_o  (frame_cnt_o)
    );

`ifdef GBT_CHK_CAPTURE_EN
    logic              cap_done_q, cap_done_d;
    logic [DATA_W-1:0] cap_rx_q, cap_rx_d, cap_exp_q, cap_exp_d;

    always_comb begin
        cap_done_d = cap_done_q;
        cap_rx_d   = cap_rx_q;
        cap_exp_d  = cap_exp_q;
        if (clear_i) begin
            cap_done_d = 1'b0;
            cap_rx_d   = '0;
            cap_exp_d  = '0;
        end else if (err_inc && !cap_done_q) begin
            cap_done_d = 1'b1;
            cap_rx_d   = data_i;
            cap_exp_d  = exp_q;
        end
    end

    always_ff @(posedge clk_ik or posedge rst_ir) begin
        if (rst_ir) begin
            cap_done_q <= 1'b0;
            cap_rx_q   <= '0;
            cap_exp_q  <= '0;
        end else begin
            cap_done_q <= cap_done_d;
            cap_rx_q   <= cap_rx_d;
            cap_exp_q  <= cap_exp_d;
        end
    end

    assign cap_rx_o  = cap_rx_q;
    assign cap_exp_o = cap_exp_q;
`else
    assign cap_rx_o  = '0;
    assign cap_exp_o = '0;
`endif

    assign locked_o    = locked_q;
    assign error_o     = error_q;
    assign lost_lock_o = lost_q;

endmodule

// File: tb/tb_gbt_rx_counter_checker.sv
// Scoreboard bench for gbt_rx_counter_checker: default instance against a reference model,
// plus a CNT_W=4 / UNLOCK_COUNT=32 instance for saturation, clear and async reset.
module tb_gbt_rx_counter_checker;

    localparam int S_IDLE = 0, S_SEED = 1, S_ACQ = 2, S_LOCKED = 3;

    logic        clk = 1'b0;
    logic        rst, rdy, en, clr;
    logic [31:0] dat;
    logic        locked, error, lost;
    logic [15:0] err_cnt, frame_cnt;
    logic [31:0] cap_rx, cap_exp;

    logic        s_rst, s_rdy, s_en, s_clr;
    logic [31:0] s_dat;
    logic        s_locked, s_error, s_lost;
    logic [3:0]  s_err_cnt, s_frame_cnt;
    logic [31:0] s_cap_rx, s_cap_exp;

    int n_chk = 0;
    int n_err = 0;

    typedef struct packed {
        logic        locked;
        logic        error;
        logic        lost;
        logic [15:0] err;
        logic [15:0] frame;
        logic [31:0] crx;
        logic [31:0] cexp;
    } exp_t;

    exp_t sb_q[$];

    int          m_st, m_good, m_bad;
    logic [31:0] m_exp, m_crx, m_cexp;
    logic [15:0] m_err, m_frame;
    logic        m_lost, m_capd, m_pulse;

    always #5 clk = ~clk;

    gbt_rx_counter_checker dut (
        .clk_ik      (clk),
        .rst_ir      (rst),
        .rxready_i   (rdy),
        .clken_i     (en),
        .data_i      (dat),
        .clear_i     (clr),
        .locked_o    (locked),
        .error_o     (error),
        .lost_lock_o (lost),
        .err_cnt_o   (err_cnt),
        .frame_cnt_o (frame_cnt),
        .cap_rx_o    (cap_rx),
        .cap_exp_o   (cap_exp)
    );

    gbt_rx_counter_checker #(.CNT_W(4), .UNLOCK_COUNT(32)) dut_sat (
        .clk_ik      (clk),
        .rst_ir      (s_rst),
        .rxready_i   (s_rdy),
        .clken_i     (s_en),
        .data_i      (s_dat),
        .clear_i     (s_clr),
        .locked_o    (s_locked),
        .error_o     (s_error),
        .lost_lock_o (s_lost),
        .err_cnt_o   (s_err_cnt),
        .frame_cnt_o (s_frame_cnt),
        .cap_rx_o    (s_cap_rx),
        .cap_exp_o   (s_cap_exp)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s got %0h want %0h", tag, got, want);
        end
    endtask

    task automatic model_reset();
        m_st = S_IDLE; m_good = 0; m_bad = 0; m_exp = '0;
        m_err = '0; m_frame = '0; m_lost = 1'b0; m_capd = 1'b0;
        m_crx = '0; m_cexp = '0; m_pulse = 1'b0;
    endtask

    // Drive one cycle on the default instance, predict its outputs, then compare after the edge.
    task automatic step(input logic r, input logic e, input logic [31:0] d, input logic c);
        exp_t x, o;
        logic set_ll;
        set_ll = 1'b0;
        rdy = r; en = e; dat = d; clr = c;
        m_pulse = 1'b0;
        if (!r) begin
            m_st = S_IDLE;
        end else if (m_st == S_IDLE) begin
            m_st = S_SEED;
        end else if (e) begin
            if (m_st == S_SEED) begin
                m_good = 0;
                m_st = S_ACQ;
            end else if (m_st == S_ACQ) begin
                if (d == m_exp) begin
                    m_good++;
                    if (m_good == 8) begin m_st = S_LOCKED; m_bad = 0; end
                end else begin
                    m_good = 0;
                    m_pulse = 1'b1;
                end
            end else begin
                if (m_frame != 16'hFFFF) m_frame++;
                if (d == m_exp) begin
                    m_bad = 0;
                end else begin
                    m_pulse = 1'b1;
                    if (m_err != 16'hFFFF) m_err++;
                    if (!m_capd) begin m_crx = d; m_cexp = m_exp; m_capd = 1'b1; end
                    m_bad++;
                    if (m_bad == 4) begin m_st = S_SEED; set_ll = 1'b1; end
                end
            end
            m_exp = d + 32'd1;
        end
        if (c) begin
            m_err = '0; m_frame = '0; m_lost = 1'b0;
            m_capd = 1'b0; m_crx = '0; m_cexp = '0;
        end
        if (set_ll) m_lost = 1'b1;
        x.locked = (m_st == S_LOCKED);
        x.error  = m_pulse;
        x.lost   = m_lost;
        x.err    = m_err;
        x.frame  = m_frame;
`ifdef GBT_CHK_CAPTURE_EN
        x.crx  = m_crx;
        x.cexp = m_cexp;
`else
        x.crx  = '0;
        x.cexp = '0;
`endif
        sb_q.push_back(x);
        @(posedge clk);
        #1;
        o = sb_q.pop_front();
        chk("locked_o", locked, o.locked);
        chk("error_o", error, o.error);
        chk("lost_lock_o", lost, o.lost);
        chk("err_cnt_o", err_cnt, o.err);
        chk("frame_cnt_o", frame_cnt, o.frame);
        chk("cap_rx_o", cap_rx, o.crx);
        chk("cap_exp_o", cap_exp, o.cexp);
    endtask

    task automatic s_step(input logic e, input logic [31:0] d, input logic c);
        s_en = e; s_dat = d; s_clr = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b0; en = 1'b0; dat = '0; clr = 1'b0;
        s_rst = 1'b1; s_rdy = 1'b0; s_en = 1'b0; s_dat = '0; s_clr = 1'b0;
        model_reset();
        #2;
        chk("rst_locked", locked, 0);
        chk("rst_error", error, 0);
        chk("rst_lost", lost, 0);
        chk("rst_err_cnt", err_cnt, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        chk("rst_cap_rx", cap_rx, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Lock acquisition: seed 0 then 1..8
        step(1, 0, 0, 0);
        for (int i = 0; i <= 8; i++) step(1, 1, i, 0);
        chk("acq_locked", locked, 1);
        chk("acq_err_cnt", err_cnt, 0);
        chk("acq_frame_cnt", frame_cnt, 0);
        for (int i = 9; i <= 99; i++) step(1, 1, i, 0);
        chk("run_frame_cnt", frame_cnt, 91);

        // Single corrupt word: 0xDEAD mismatches, then 103 mismatches against the resynced 0xDEAE
        step(1, 1, 100, 0);
        step(1, 1, 101, 0);
        step(1, 1, 32'hDEAD, 0);
        chk("single_err_pulse", error, 1);
        step(1, 1, 103, 0);
        step(1, 1, 104, 0);
        chk("single_err_cnt", err_cnt, 2);
        chk("single_locked", locked, 1);
`ifdef GBT_CHK_CAPTURE_EN
        chk("cap_rx_dead", cap_rx, 32'hDEAD);
        chk("cap_exp_102", cap_exp, 102);
`endif

        // Clear on the same cycle as a frame increment
        step(1, 1, 105, 1);
        chk("clr_frame_cnt", frame_cnt, 0);
        chk("clr_err_cnt", err_cnt, 0);

        // Loss of lock: four non-sequential words
        for (int i = 0; i < 4; i++) step(1, 1, m_exp + 32'd5 + $urandom_range(0, 1000), 0);
        chk("loss_locked", locked, 0);
        chk("loss_lost", lost, 1);
        chk("loss_err_cnt", err_cnt, 4);

        // Relock so that the counter then walks across the 32-bit wrap
        for (int i = 0; i < 9; i++) step(1, 1, 32'hFFFF_FFF5 + i, 0);
        chk("relock_locked", locked, 1);
        step(1, 1, 32'hFFFF_FFFE, 0);
        step(1, 1, 32'hFFFF_FFFF, 0);
        step(1, 1, 32'h0000_0000, 0);
        chk("wrap_no_err", error, 0);
        step(1, 1, 32'h0000_0001, 0);
        chk("wrap_frame_cnt", frame_cnt, 8);
        chk("wrap_err_cnt", err_cnt, 4);

        // clken gating
        for (int k = 0; k < 10; k++) begin
            step(1, 1, 2 + k, 0);
            step(1, 0, 2 + k, 0);
        end
        chk("gate_err_cnt", err_cnt, 4);
        chk("gate_frame_cnt", frame_cnt, 18);

        // rxready drop for three cycles
        for (int k = 0; k < 3; k++) step(0, 1, 32'h1234 + k, 0);
        chk("rdy_locked", locked, 0);
        chk("rdy_frame_held", frame_cnt, 18);
        chk("rdy_err_held", err_cnt, 4);
        step(1, 0, 0, 0);
        for (int i = 0; i < 9; i++) step(1, 1, 500 + i, 0);
        chk("rdy_relock", locked, 1);

        // Unlock coinciding with clear: the sticky flag survives
        for (int i = 0; i < 3; i++) step(1, 1, 32'h7777, 0);
        step(1, 1, 32'h7777, 1);
        chk("setclr_lost", lost, 1);
        chk("setclr_err_cnt", err_cnt, 0);

        // Async reset mid-operation
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("arst_error", error, 0);
        chk("arst_locked", locked, 0);
        chk("arst_lost", lost, 0);
        chk("arst_err_cnt", err_cnt, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(1, 0, 0, 0);
        for (int i = 0; i <= 8; i++) step(1, 1, 40 + i, 0);

        // Saturation instance
        s_rst = 1'b0;
        s_rdy = 1'b1;
        s_step(0, 0, 0);
        for (int i = 0; i <= 8; i++) s_step(1, i, 0);
        chk("sat_locked", s_locked, 1);
        for (int i = 0; i < 20; i++) s_step(1, 32'h55, 0);
        chk("sat_err_cnt", s_err_cnt, 15);
        chk("sat_frame_cnt", s_frame_cnt, 15);
        chk("sat_still_locked", s_locked, 1);
        s_step(0, 0, 1);
        chk("sat_clr_err", s_err_cnt, 0);
        chk("sat_clr_frame", s_frame_cnt, 0);
        s_step(1, 32'h55, 1);
        chk("sat_clr_wins", s_err_cnt, 0);
        for (int i = 0; i < 3; i++) s_step(1, 32'h55, 0);
        chk("sat_err_3", s_err_cnt, 3);
        #2;
        s_rst = 1'b1;
        #1;
        chk("sat_arst_err", s_err_cnt, 0);
        chk("sat_arst_frame", s_frame_cnt, 0);
        chk("sat_arst_locked", s_locked, 0);
        chk("sat_arst_error", s_error, 0);
        chk("sat_arst_lost", s_lost, 0);
        chk("sat_arst_cap", {s_cap_rx, s_cap_exp}, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
